// File: rtl/axis_histogram_sequencer_pkg.sv
// Shared definitions for the histogram acquisition sequencer.
// The state encoding is visible to software through sts_state.
package axis_histogram_sequencer_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/axis_histogram_sequencer_if.sv
// AXI-Stream bundle. A beat transfers on a clock edge where tvalid and tready are both 1;
// the master holds tdata/tlast stable from tvalid rising until that edge.
interface axis_histogram_sequencer_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_histogram_sequencer_edge_detect.sv
// Synchronises the cfg_run level and produces a one-cycle rising-edge pulse.
module axis_histogram_sequencer_edge_detect (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_level,
    output logic o_level,
    output logic o_rise
);
    logic r_sync;
    logic r_prev;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= i_level;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
endmodule

// File: rtl/axis_histogram_sequencer.sv
// Acquisition controller: gates events into the histogram accumulator for a bounded run,
// then streams every bin out through BRAM port B, optionally zeroing each bin after it is sent.
module axis_histogram_sequencer
    import axis_histogram_sequencer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 14,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_run,
    input  logic                       cfg_clear,
    input  logic [CNTR_WIDTH-1:0]      cfg_event_limit,
    input  logic [CNTR_WIDTH-1:0]      cfg_time_limit,
    output logic [STATE_WIDTH-1:0]     sts_state,
    output logic [CNTR_WIDTH-1:0]      sts_events,
    output logic [CNTR_WIDTH-1:0]      sts_time,
    output logic                       sts_done,
    axis_histogram_sequencer_if.slave  s_axis,
    axis_histogram_sequencer_if.master m_axis,
    axis_histogram_sequencer_if.master m_axis_rd,
    output logic                       bram_portb_clk,
    output logic                       bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_portb_wrdata,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata,
    output logic                       bram_portb_we
);
    state_t                     r_state, w_state_nxt;
    logic                       r_en;
    logic [CNTR_WIDTH-1:0]      r_events, w_events_nxt, w_events_inc;
    logic [CNTR_WIDTH-1:0]      r_time, w_time_nxt, w_time_inc;
    logic                       r_done, w_done_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic                       w_run_level, w_run_rise;
    logic                       w_hs, w_time_hit, w_event_hit;
    logic                       w_s_tready, w_m_tvalid, w_we;
    logic                       w_unused;

    axis_histogram_sequencer_edge_detect u_run_edge (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_level (cfg_run),
        .o_level (w_run_level),
        .o_rise  (w_run_rise)
    );

    // Counters stick at all-ones instead of wrapping
    assign w_time_inc   = (&r_time)   ? r_time   : r_time + 1'b1;
    assign w_events_inc = (&r_events) ? r_events : r_events + 1'b1;
    assign w_hs         = s_axis.tvalid & m_axis.tready;
    assign w_time_hit   = (|cfg_time_limit) && ((r_time + 1'b1) == cfg_time_limit);
    assign w_event_hit  = (|cfg_event_limit) && w_hs && (w_events_inc == cfg_event_limit);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_en     <= 1'b0;
            r_events <= '0;
            r_time   <= '0;
            r_done   <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_en     <= 1'b1;
            r_events <= w_events_nxt;
            r_time   <= w_time_nxt;
            r_done   <= w_done_nxt;
            r_addr   <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_events_nxt = r_events;
        w_time_nxt   = r_time;
        w_done_nxt   = r_done;
        w_addr_nxt   = r_addr;
        w_s_tready   = r_en;
        w_m_tvalid   = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run_rise) begin
                    w_events_nxt = '0;
                    w_time_nxt   = '0;
                    w_done_nxt   = 1'b0;
                    w_state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_m_tvalid = s_axis.tvalid;
                w_s_tready = m_axis.tready;
                w_time_nxt = w_time_inc;
                if (w_hs) w_events_nxt = w_events_inc;
                if (!w_run_level || w_time_hit || w_event_hit) w_state_nxt = ST_DRAIN;
            end
            // Accumulator ready again means its last read-modify-write has retired
            ST_DRAIN: begin
                if (m_axis.tready) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: w_state_nxt = ST_RD_DATA;
            ST_RD_DATA: begin
                if (m_axis_rd.tready) begin
                    w_we = cfg_clear;
                    if (&r_addr) begin
                        w_addr_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = ST_RD_ADDR;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign s_axis.tready = w_s_tready;
    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tvalid = w_m_tvalid;
    assign m_axis.tlast  = 1'b0;

    // The BRAM output register holds the bin; addr and we stay put while the readout stalls
    assign m_axis_rd.tdata  = bram_portb_rddata;
    assign m_axis_rd.tvalid = (r_state == ST_RD_DATA);
    assign m_axis_rd.tlast  = (r_state == ST_RD_DATA) && (&r_addr);

    assign bram_portb_clk    = aclk;
    assign bram_portb_rst    = ~aresetn;
    assign bram_portb_addr   = r_addr;
    assign bram_portb_wrdata = '0;
    assign bram_portb_we     = w_we;

    assign sts_state  = r_state;
    assign sts_events = r_events;
    assign sts_time   = r_time;
    assign sts_done   = r_done;

    assign w_unused = s_axis.tlast;
endmodule

// File: tb/tb_axis_histogram_sequencer.sv
// Directed bench for axis_histogram_sequencer with a 16-bin BRAM model on port B.
module tb_axis_histogram_sequencer;
  localparam int TW = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 32;
  localparam int NBINS = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_run, cfg_clear;
  logic [CW-1:0] cfg_event_limit, cfg_time_limit;
  logic [2:0]    sts_state;
  logic [CW-1:0] sts_events, sts_time;
  logic          sts_done;
  logic          bram_portb_clk, bram_portb_rst, bram_portb_we;
  logic [AW-1:0] bram_portb_addr;
  logic [DW-1:0] bram_portb_wrdata, bram_portb_rddata;
  logic          bram_init;
  logic [DW-1:0] mem [NBINS];

  axis_histogram_sequencer_if #(.W(TW)) s_if ();
  axis_histogram_sequencer_if #(.W(TW)) m_if ();
  axis_histogram_sequencer_if #(.W(DW)) rd_if ();

  axis_histogram_sequencer #(
    .AXIS_TDATA_WIDTH(TW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CNTR_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_run(cfg_run), .cfg_clear(cfg_clear),
    .cfg_event_limit(cfg_event_limit), .cfg_time_limit(cfg_time_limit),
    .sts_state(sts_state), .sts_events(sts_events), .sts_time(sts_time), .sts_done(sts_done),
    .s_axis(s_if), .m_axis(m_if), .m_axis_rd(rd_if),
    .bram_portb_clk(bram_portb_clk), .bram_portb_rst(bram_portb_rst),
    .bram_portb_addr(bram_portb_addr), .bram_portb_wrdata(bram_portb_wrdata),
    .bram_portb_rddata(bram_portb_rddata), .bram_portb_we(bram_portb_we)
  );

  // clock / reset-independent models
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    if (bram_init) begin
      for (int i = 0; i < NBINS; i++) mem[i] <= DW'(i);
    end else if (bram_portb_we) begin
      mem[bram_portb_addr] <= bram_portb_wrdata;
    end
    bram_portb_rddata <= mem[bram_portb_addr];
  end

  int acc_cnt = 0;
  logic [TW-1:0] acc_q[$];
  always @(posedge aclk) begin
    if (aresetn && m_if.tvalid && m_if.tready) begin
      acc_cnt <= acc_cnt + 1;
      acc_q.push_back(m_if.tdata);
    end
  end

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic preload();
    bram_init = 1'b1;
    tick();
    bram_init = 1'b0;
  endtask

  task automatic load_exp_ramp();
    exp_q.delete();
    for (int i = 0; i < NBINS; i++) exp_q.push_back(DW'(i));
  endtask

  task automatic start_run();
    cfg_run = 1'b0;
    tick(); tick(); tick();
    cfg_run = 1'b1;
    tick(); tick();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!sts_done && n < 200) begin
      tick();
      n++;
    end
    check(tag, sts_done, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, sts_state, 3'd0);
    check({tag, "_s_tready"}, s_if.tready, 1'b0);
    check({tag, "_m_tvalid"}, m_if.tvalid, 1'b0);
    check({tag, "_rd_tvalid"}, rd_if.tvalid, 1'b0);
    check({tag, "_rd_tlast"}, rd_if.tlast, 1'b0);
    check({tag, "_we"}, bram_portb_we, 1'b0);
    check({tag, "_addr"}, bram_portb_addr, '0);
    check({tag, "_wrdata"}, bram_portb_wrdata, '0);
    check({tag, "_events"}, sts_events, '0);
    check({tag, "_time"}, sts_time, '0);
    check({tag, "_done"}, sts_done, 1'b0);
    check({tag, "_bram_rst"}, bram_portb_rst, 1'b1);
  endtask

  // Drains one full readout, comparing every beat against exp_q
  task automatic collect(input bit rand_rdy, input bit exp_clear, input string tag);
    logic [DW-1:0] prev_data;
    bit stalled;
    int n, t, first_cyc, last_cyc;
    stalled = 0; n = 0; t = 0; first_cyc = 0; last_cyc = 0; prev_data = '0;
    while (n < NBINS && t < 2000) begin
      rd_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        check({tag, "_stall_valid"}, rd_if.tvalid, 1'b1);
        check({tag, "_stall_data"}, rd_if.tdata, prev_data);
      end
      if (rd_if.tvalid && rd_if.tready) begin
        check({tag, "_data"}, rd_if.tdata, exp_q.pop_front());
        check({tag, "_last"}, rd_if.tlast, n == NBINS - 1);
        check({tag, "_addr"}, bram_portb_addr, n);
        check({tag, "_we"}, bram_portb_we, exp_clear);
        if (n == 0) first_cyc = cyc;
        last_cyc = cyc;
        n++;
      end
      stalled = rd_if.tvalid && !rd_if.tready;
      prev_data = rd_if.tdata;
      tick();
      t++;
    end
    check({tag, "_beats"}, n, NBINS);
    if (!rand_rdy) check({tag, "_throughput"}, last_cyc - first_cyc, 2 * (NBINS - 1));
    check({tag, "_idle"}, sts_state, 3'd0);
    check({tag, "_done"}, sts_done, 1'b1);
    rd_if.tready = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] acc_or;
    int bad;

    // clock/reset block
    aresetn = 1'b0; cfg_run = 1'b0; cfg_clear = 1'b0;
    cfg_event_limit = '0; cfg_time_limit = '0; bram_init = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1; rd_if.tready = 1'b0;
    tick(); tick(); tick();
    check_reset_values("reset");
    aresetn = 1'b1;
    #1;
    check("en_first_cycle", s_if.tready, 1'b0);
    tick();
    check("en_after", s_if.tready, 1'b1);
    preload();

    // event limit 5, eight events offered
    cfg_event_limit = 32'd5; cfg_time_limit = '0;
    s_if.tvalid = 1'b1; s_if.tdata = 16'hABCD;
    #1;
    check("idle_discard_ready", s_if.tready, 1'b1);
    check("idle_no_forward", m_if.tvalid, 1'b0);
    start_run();
    check("a_run", sts_state, 3'd1);
    check("a_events0", sts_events, 0);
    acc_q.delete();
    n = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      s_if.tdata = TW'(i);
      #1;
      check("a_accept", s_if.tready, 1'b1);
      if (i == 0) check("a_passthrough", m_if.tdata, 16'h0000);
      tick();
    end
    s_if.tvalid = 1'b0;
    check("a_forwarded", acc_cnt - n, 5);
    for (int i = 0; i < 5; i++) check("a_fwd_data", acc_q.pop_front(), i);
    check("a_events", sts_events, 5);
    check("a_time", sts_time, 5);
    check("a_in_readout", sts_state, 3'd4);
    load_exp_ramp();
    collect(1'b0, 1'b0, "a_rd");

    // time limit 100, continuous valid, then readout with clear
    cfg_event_limit = '0; cfg_time_limit = 32'd100; cfg_clear = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 16'h0055;
    n = acc_cnt;
    start_run();
    check("b_run", sts_state, 3'd1);
    check("b_done_cleared", sts_done, 1'b0);
    begin
      int rc;
      rc = 0;
      while (sts_state == 3'd1 && rc < 200) begin
        rc++;
        tick();
      end
      check("b_run_cycles", rc, 100);
    end
    s_if.tvalid = 1'b0;
    check("b_drain", sts_state, 3'd2);
    check("b_time", sts_time, 100);
    check("b_events", sts_events, 100);
    check("b_forwarded", acc_cnt - n, 100);
    load_exp_ramp();
    collect(1'b0, 1'b1, "c_rd");
    acc_or = '0;
    for (int i = 0; i < NBINS; i++) acc_or = acc_or | mem[i];
    check("c_bram_cleared", acc_or, '0);

    // random readout backpressure, no clear
    preload();
    cfg_clear = 1'b0; cfg_time_limit = 32'd3;
    start_run();
    check("d_run", sts_state, 3'd1);
    load_exp_ramp();
    collect(1'b1, 1'b0, "d_rd");
    bad = 0;
    for (int i = 0; i < NBINS; i++) if (mem[i] !== DW'(i)) bad++;
    check("d_bram_unchanged", bad, 0);

    // accumulator busy when the event limit hits
    cfg_time_limit = '0; cfg_event_limit = 32'd2;
    m_if.tready = 1'b1;
    start_run();
    check("e_run", sts_state, 3'd1);
    s_if.tvalid = 1'b1; s_if.tdata = 16'h0003;
    tick(); tick();
    check("e_drain", sts_state, 3'd2);
    check("e_events", sts_events, 2);
    m_if.tready = 1'b0; s_if.tvalid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("e_drain_hold", sts_state, 3'd2);
      check("e_drain_no_fwd", m_if.tvalid, 1'b0);
      tick();
    end
    m_if.tready = 1'b1;
    tick();
    check("e_rd_addr", sts_state, 3'd3);
    tick();
    check("e_rd_data", sts_state, 3'd4);
    load_exp_ramp();
    collect(1'b0, 1'b0, "e_rd");

    // reset while presenting bin 7, then a clean run
    cfg_event_limit = '0; cfg_time_limit = 32'd2; cfg_clear = 1'b1;
    start_run();
    rd_if.tready = 1'b1;
    n = 0;
    while (!(rd_if.tvalid && rd_if.tdata == 32'd7) && n < 200) begin
      tick();
      n++;
    end
    check("f_at_bin7", rd_if.tvalid, 1'b1);
    check("f_addr7", bram_portb_addr, 7);
    rd_if.tready = 1'b0; aresetn = 1'b0; cfg_run = 1'b0;
    tick();
    check_reset_values("f_reset");
    check("f_bin6_cleared", mem[6], 0);
    check("f_bin7_kept", mem[7], 7);
    check("f_bin15_kept", mem[15], 15);
    aresetn = 1'b1;
    tick();
    cfg_time_limit = '0; cfg_event_limit = 32'd3;
    s_if.tvalid = 1'b1;
    start_run();
    check("f_run", sts_state, 3'd1);
    check("f_events0", sts_events, 0);
    check("f_time0", sts_time, 0);
    check("f_done0", sts_done, 1'b0);
    tick(); tick(); tick();
    s_if.tvalid = 1'b0;
    check("f_drain", sts_state, 3'd2);
    check("f_events", sts_events, 3);
    rd_if.tready = 1'b1;
    wait_done("f_done");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
